control_unit: RTL and testbench
===============================

# control_unit

Instruction-sequencing control unit for the OrgaSmall datapath, driving the same `alu` opcode interface the datapath consumes. It fetches 16-bit instructions from instruction memory over a request/acknowledge handshake and decodes them. It then emits per-instruction control for the ALU, register file and flags, and maintains the PC, including conditional jumps on the datapath flags. It sits between instruction memory and the datapath: the datapath executes the operation, and this block decides which one.

## Interface
- `WORD_SIZE`, 16: instruction width
- `ADDR_SIZE`, 8: PC and instruction-memory address width
- `DATA_SIZE`, 8: immediate width
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `imem_req` out 1: fetch request
- `imem_addr` out ADDR_SIZE: fetch address, equals PC
- `imem_ack` in 1: fetch complete, `imem_rdata` valid this cycle
- `imem_rdata` in WORD_SIZE: instruction word
- `alu_opcode` out opcode_t: operation for the ALU
- `alu_b_sel` out 1: 0 = Ry, 1 = immediate
- `rf_rx` out 3, `rf_ry` out 3: register indices
- `rf_we` out 1: register write strobe (Rx)
- `rf_wsel` out 2: write source, 0 = ALU out, 1 = Ry, 2 = immediate
- `imm` out DATA_SIZE: immediate M
- `flags_we` out 1: latch Z/C/N from the ALU result
- `flag_z`, `flag_c`, `flag_n` in 1: current datapath flags
- `illegal` out 1: sticky undefined-opcode indicator (only when the macro is defined)

## Operation
- Instruction format: [15:11] opcode, [10:8] Rx, [7:5] Ry, [7:0] M.
- Encodings:
  - ALU ops: ADD 00001, ADC 00010, SUB 00011, AND 00100, OR 00101, XOR 00110, CMP 00111.
  - Moves: MOV 01000, SET 11111.
  - Jumps: JMP 10100, JC 10101, JZ 10110, JN 10111.
  - Unary/shift: INC 11000, DEC 11001, SHR 11010, SHL 11011.
- FSM states:
  - FETCH: `imem_req`=1. On `imem_ack`, capture the word into IR and go to DECODE.
  - DECODE: register the control word; no strobes asserted.
  - EXECUTE: assert strobes for one cycle, update PC, go to FETCH.
  - HALT: only reachable with the macro defined.
- Per-opcode behaviour:
  - ADD/ADC/SUB/AND/OR/XOR: `alu_b_sel`=0, `rf_we`=1, `rf_wsel`=0, `flags_we`=1.
  - CMP: `flags_we`=1 only.
  - INC/DEC: `rf_we`=1, `flags_we`=1.
  - SHR/SHL: `alu_b_sel`=1, `rf_we`=1, `flags_we`=1.
  - MOV: `rf_we`=1, `rf_wsel`=1.
  - SET: `rf_we`=1, `rf_wsel`=2.
- PC update in EXECUTE:
  - Default is PC+2, modulo 2^ADDR_SIZE.
  - JMP sets PC to M.
  - JC/JZ/JN set PC to M if C/Z/N is 1 in the EXECUTE cycle, otherwise PC+2.
- Undefined opcodes: no strobes; PC+2.
- `alu_opcode`, `rf_rx`, `rf_ry`, `imm`, `alu_b_sel`, `rf_wsel` are held from DECODE through EXECUTE and are stable while the strobes are high.

## Timing
- Reset values:
  - PC=0x00, state FETCH.
  - All outputs 0: `imem_req`, `rf_we`, `flags_we`, `illegal`, indices, `imm`; `alu_opcode`='0.
- Reset is asynchronous: all outputs drop immediately.
- `imem_req` rises in the first clock edge after `rst_n` deasserts.
- Handshake:
  - `imem_req` and `imem_addr` are held stable until the cycle `imem_ack`=1.
  - `imem_req` drops the cycle after the ack.
  - `imem_ack` outside FETCH is ignored.
- Latency: 3 cycles per instruction with same-cycle ack (FETCH, DECODE, EXECUTE), plus one cycle per ack wait cycle.
- `rf_we`/`flags_we` are exactly one-cycle pulses, once per instruction.
- Flags are sampled only in EXECUTE, so a flag change in DECODE is visible to a following jump.
- Reset during FETCH wait or EXECUTE: no strobe completes, and the pending ack is discarded.

## Configuration
- `CU_ILLEGAL_HALT_EN` defined:
  - An undefined opcode in EXECUTE sets `illegal`=1, which is sticky until reset.
  - The FSM enters HALT: no further `imem_req`, no strobes.
- Not defined:
  - Undefined opcodes execute as NOP with PC+2.
  - The `illegal` port is tied 0, and there is no HALT state.

## Structure
- The shared config package holds:
  - opcode_t, extended with MOV/SET/JMP/JC/JZ/JN encodings.
  - The cu_state_t enum.
  - Instruction-field bit positions.
  - The wsel constants.
- Sub-module `instr_decode`: a purely combinational mapping from opcode to control word (strobes, selects, jump type, legal).
- `control_unit` holds the FSM, PC, IR and handshake.

## Test plan
- Reset release, same-cycle ack, rdata 0x0920 (ADD R1,R1) →
  - Fetch at 0x00.
  - In EXECUTE (3rd cycle): `alu_opcode`=ADD, rx=1, ry=1, `rf_we`=`flags_we`=1, `rf_wsel`=0.
  - Next `imem_addr`=0x02.
- 0xFB5A (SET R3,0x5A) → in EXECUTE `rf_we`=1, `rf_wsel`=2, `imm`=0x5A, rx=3, `flags_we`=0.
- 0xB040 (JZ 0x40):
  - With `flag_z`=1, next fetch at 0x40.
  - With `flag_z`=0, next fetch at PC+2.
- Ack delayed 4 cycles → `imem_req`=1 and `imem_addr` constant for 5 cycles, no strobes; EXECUTE follows 2 cycles after the ack.
- 0xA0FE (JMP 0xFE), then 0x0000 at 0xFE:
  - With macro: `illegal`=1, `imem_req` stays 0.
  - Without macro: no strobes, next fetch wraps to 0x00.
- `rst_n` pulsed low during an ack wait → `imem_req`=0 immediately; the next fetch is at 0x00, and the late ack produces no strobe.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared types and constants for the OrgaSmall control unit.
// The StHalt state exists only when CU_ILLEGAL_HALT_EN is defined.
package control_unit_pkg;

   typedef enum logic [4:0] {
      OpNop = 5'b00000,
      OpAdd = 5'b00001,
      OpAdc = 5'b00010,
      OpSub = 5'b00011,
      OpAnd = 5'b00100,
      OpOr  = 5'b00101,
      OpXor = 5'b00110,
      OpCmp = 5'b00111,
      OpMov = 5'b01000,
      OpJmp = 5'b10100,
      OpJc  = 5'b10101,
      OpJz  = 5'b10110,
      OpJn  = 5'b10111,
      OpInc = 5'b11000,
      OpDec = 5'b11001,
      OpShr = 5'b11010,
      OpShl = 5'b11011,
      OpSet = 5'b11111
   } opcode_t;

   typedef enum logic [1:0] {
      StFetch   = 2'd0,
      StDecode  = 2'd1,
      StExecute = 2'd2
`ifdef CU_ILLEGAL_HALT_EN
      , StHalt  = 2'd3
`endif
   } cu_state_t;

   typedef enum logic [2:0] {
      JmpNone   = 3'd0,
      JmpAlways = 3'd1,
      JmpC      = 3'd2,
      JmpZ      = 3'd3,
      JmpN      = 3'd4
   } jump_t;

   // Strobes and jump kind, registered in DECODE and consumed in EXECUTE.
   typedef struct packed {
      logic  legal;
      logic  rf_we;
      logic  flags_we;
      jump_t jump;
   } ctrl_t;

   localparam int unsigned OpMsb  = 15;
   localparam int unsigned OpLsb  = 11;
   localparam int unsigned RxMsb  = 10;
   localparam int unsigned RxLsb  = 8;
   localparam int unsigned RyMsb  = 7;
   localparam int unsigned RyLsb  = 5;
   localparam int unsigned ImmMsb = 7;
   localparam int unsigned ImmLsb = 0;

   localparam logic [1:0] WselAlu = 2'd0;
   localparam logic [1:0] WselRy  = 2'd1;
   localparam logic [1:0] WselImm = 2'd2;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: maps an opcode to strobes, selects and jump kind.
module instr_decode
   import control_unit_pkg::*;
(
   input  opcode_t    opcode,
   output ctrl_t      ctrl,
   output logic       alu_b_sel,
   output logic [1:0] rf_wsel
);

   always_comb begin
      ctrl      = '0;
      ctrl.jump = JmpNone;
      alu_b_sel = 1'b0;
      rf_wsel   = WselAlu;
      unique case (opcode)
         OpAdd, OpAdc, OpSub, OpAnd, OpOr, OpXor, OpInc, OpDec: begin
            ctrl.legal    = 1'b1;
            ctrl.rf_we    = 1'b1;
            ctrl.flags_we = 1'b1;
         end
         OpCmp: begin
            ctrl.legal    = 1'b1;
            ctrl.flags_we = 1'b1;
         end
         OpShr, OpShl: begin
            ctrl.legal    = 1'b1;
            ctrl.rf_we    = 1'b1;
            ctrl.flags_we = 1'b1;
            alu_b_sel     = 1'b1;
         end
         OpMov: begin
            ctrl.legal = 1'b1;
            ctrl.rf_we = 1'b1;
            rf_wsel    = WselRy;
         end
         OpSet: begin
            ctrl.legal = 1'b1;
            ctrl.rf_we = 1'b1;
            rf_wsel    = WselImm;
         end
         OpJmp: begin
            ctrl.legal = 1'b1;
            ctrl.jump  = JmpAlways;
         end
         OpJc: begin
            ctrl.legal = 1'b1;
            ctrl.jump  = JmpC;
         end
         OpJz: begin
            ctrl.legal = 1'b1;
            ctrl.jump  = JmpZ;
         end
         OpJn: begin
            ctrl.legal = 1'b1;
            ctrl.jump  = JmpN;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// OrgaSmall instruction sequencer: fetch handshake, decode, one-cycle execute strobes, PC.
// Define CU_ILLEGAL_HALT_EN to halt with a sticky `illegal` flag on undefined opcodes.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned DATA_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req,
   output logic [ADDR_SIZE-1:0] imem_addr,
   input  logic                 imem_ack,
   input  logic [WORD_SIZE-1:0] imem_rdata,
   output opcode_t              alu_opcode,
   output logic                 alu_b_sel,
   output logic [2:0]           rf_rx,
   output logic [2:0]           rf_ry,
   output logic                 rf_we,
   output logic [1:0]           rf_wsel,
   output logic [DATA_SIZE-1:0] imm,
   output logic                 flags_we,
   input  logic                 flag_z,
   input  logic                 flag_c,
   input  logic                 flag_n,
   output logic                 illegal
);

   cu_state_t            state_q, state_d;
   logic                 req_q;
   logic [ADDR_SIZE-1:0] pc_q, pc_d;
   logic [WORD_SIZE-1:0] ir_q;
   ctrl_t                ctrl_q, dec_ctrl;
   logic                 fetch_done;
   logic                 exec_ok;
   logic                 jump_taken;

   instr_decode u_decode (
      .opcode    (opcode_t'(ir_q[OpMsb:OpLsb])),
      .ctrl      (dec_ctrl),
      .alu_b_sel (alu_b_sel),
      .rf_wsel   (rf_wsel)
   );

   // req_q gates the ack so nothing is accepted in the first cycle after reset.
   assign fetch_done = (state_q == StFetch) && req_q && imem_ack;
   assign exec_ok    = (state_q == StExecute) && ctrl_q.legal;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      jump_taken = 1'b0;
      case (state_q)
         StFetch:  if (fetch_done) state_d = StDecode;
         StDecode: state_d = StExecute;
         StExecute: begin
            case (ctrl_q.jump)
               JmpAlways: jump_taken = 1'b1;
               JmpC:      jump_taken = flag_c;
               JmpZ:      jump_taken = flag_z;
               JmpN:      jump_taken = flag_n;
               default:   jump_taken = 1'b0;
            endcase
            pc_d    = jump_taken ? ADDR_SIZE'(ir_q[ImmMsb:ImmLsb]) : pc_q + ADDR_SIZE'(2);
            state_d = StFetch;
`ifdef CU_ILLEGAL_HALT_EN
            if (!ctrl_q.legal) state_d = StHalt;
`endif
         end
`ifdef CU_ILLEGAL_HALT_EN
         StHalt:   state_d = StHalt;
`endif
         default:  state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         req_q   <= 1'b0;
         pc_q    <= '0;
         ir_q    <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= (state_d == StFetch);
         pc_q    <= pc_d;
         if (fetch_done) ir_q <= imem_rdata;
         if (state_q == StDecode) ctrl_q <= dec_ctrl;
      end
   end

`ifdef CU_ILLEGAL_HALT_EN
   logic illegal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_q <= 1'b0;
      else if ((state_q == StExecute) && !ctrl_q.legal) illegal_q <= 1'b1;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign alu_opcode = opcode_t'(ir_q[OpMsb:OpLsb]);
   assign rf_rx      = ir_q[RxMsb:RxLsb];
   assign rf_ry      = ir_q[RyMsb:RyLsb];
   assign imm        = DATA_SIZE'(ir_q[ImmMsb:ImmLsb]);
   assign rf_we      = exec_ok && ctrl_q.rf_we;
   assign flags_we   = exec_ok && ctrl_q.flags_we;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expectations hand-computed from the ISA.
module tb_control_unit;
   import control_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   opcode_t     alu_opcode;
   logic        alu_b_sel;
   logic [2:0]  rf_rx, rf_ry;
   logic        rf_we;
   logic [1:0]  rf_wsel;
   logic [7:0]  imm;
   logic        flags_we;
   logic        flag_z, flag_c, flag_n;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   control_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .alu_opcode (alu_opcode),
      .alu_b_sel  (alu_b_sel),
      .rf_rx      (rf_rx),
      .rf_ry      (rf_ry),
      .rf_we      (rf_we),
      .rf_wsel    (rf_wsel),
      .imm        (imm),
      .flags_we   (flags_we),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .flag_n     (flag_n),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts at a FETCH sample point; returns sampled in the EXECUTE cycle.
   task automatic run_instr(input logic [15:0] word);
      check("req_before_fetch", {31'd0, imem_req}, 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
      check("decode_no_rf_we", {31'd0, rf_we}, 32'd0);
      check("decode_no_flags_we", {31'd0, flags_we}, 32'd0);
      tick();
   endtask

   initial begin
      rst_n      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      flag_z     = 1'b0;
      flag_c     = 1'b0;
      flag_n     = 1'b0;
      #1;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", {24'd0, imem_addr}, 32'd0);
      check("rst_opcode", {27'd0, alu_opcode}, 32'd0);
      check("rst_idx_imm", {18'd0, rf_rx, rf_ry, imm}, 32'd0);
      check("rst_strobes", {29'd0, rf_we, flags_we, illegal}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      check("req_low_before_edge", {31'd0, imem_req}, 32'd0);
      tick();
      check("req_rises", {31'd0, imem_req}, 32'd1);
      check("fetch_addr0", {24'd0, imem_addr}, 32'h00);

      // ADD R1,R1
      run_instr(16'h0920);
      check("add_opcode", {27'd0, alu_opcode}, {27'd0, OpAdd});
      check("add_rx_ry", {26'd0, rf_rx, rf_ry}, {26'd0, 3'd1, 3'd1});
      check("add_we_fwe", {30'd0, rf_we, flags_we}, 32'd3);
      check("add_wsel", {30'd0, rf_wsel}, 32'd0);
      tick();
      check("add_next_addr", {24'd0, imem_addr}, 32'h02);
      check("add_we_pulse", {30'd0, rf_we, flags_we}, 32'd0);

      // SET R3,0x5A
      run_instr(16'hFB5A);
      check("set_we", {31'd0, rf_we}, 32'd1);
      check("set_wsel", {30'd0, rf_wsel}, 32'd2);
      check("set_imm", {24'd0, imm}, 32'h5A);
      check("set_rx", {29'd0, rf_rx}, 32'd3);
      check("set_fwe", {31'd0, flags_we}, 32'd0);
      tick();
      check("set_next_addr", {24'd0, imem_addr}, 32'h04);

      // JZ 0x40, taken; Z raised during DECODE
      check("jz_req", {31'd0, imem_req}, 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = 16'hB040;
      tick();
      imem_ack   = 1'b0;
      flag_z     = 1'b1;
      tick();
      check("jz_no_strobes", {30'd0, rf_we, flags_we}, 32'd0);
      tick();
      check("jz_taken_addr", {24'd0, imem_addr}, 32'h40);

      // JZ 0x40, not taken
      flag_z = 1'b0;
      run_instr(16'hB040);
      tick();
      check("jz_not_taken_addr", {24'd0, imem_addr}, 32'h42);

      // Ack delayed 4 cycles, then OR R3,R3
      for (int i = 0; i < 5; i++) begin
         check("wait_req", {31'd0, imem_req}, 32'd1);
         check("wait_addr", {24'd0, imem_addr}, 32'h42);
         check("wait_no_strobes", {30'd0, rf_we, flags_we}, 32'd0);
         if (i == 4) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'h2B60;
         end
         tick();
      end
      imem_ack = 1'b0;
      check("ack_req_drops", {31'd0, imem_req}, 32'd0);
      tick();
      check("or_opcode", {27'd0, alu_opcode}, {27'd0, OpOr});
      check("or_we_fwe", {30'd0, rf_we, flags_we}, 32'd3);
      tick();
      check("or_next_addr", {24'd0, imem_addr}, 32'h44);

      // SHR R1,#1: immediate operand select held from DECODE
      imem_ack   = 1'b1;
      imem_rdata = 16'hD101;
      tick();
      imem_ack   = 1'b0;
      check("shr_bsel_decode", {31'd0, alu_b_sel}, 32'd1);
      tick();
      check("shr_bsel_exec", {31'd0, alu_b_sel}, 32'd1);
      check("shr_we_fwe", {30'd0, rf_we, flags_we}, 32'd3);
      tick();
      check("shr_next_addr", {24'd0, imem_addr}, 32'h46);

      // JMP 0xFE, then undefined 0x0000 at 0xFE
      run_instr(16'hA0FE);
      tick();
      check("jmp_addr", {24'd0, imem_addr}, 32'hFE);
      run_instr(16'h0000);
      check("undef_no_strobes", {30'd0, rf_we, flags_we}, 32'd0);
      tick();
`ifdef CU_ILLEGAL_HALT_EN
      check("undef_illegal", {31'd0, illegal}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("halt_no_req", {31'd0, imem_req}, 32'd0);
         tick();
      end
      check("halt_illegal_sticky", {31'd0, illegal}, 32'd1);
`else
      check("undef_wrap_addr", {24'd0, imem_addr}, 32'h00);
      check("undef_req", {31'd0, imem_req}, 32'd1);
      check("undef_illegal_tied", {31'd0, illegal}, 32'd0);
`endif

      // Clean restart, then reset asserted during an ack wait
      rst_n = 1'b0;
      #1;
      check("rst2_illegal_clr", {31'd0, illegal}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rst2_req", {31'd0, imem_req}, 32'd1);
      check("rst2_addr", {24'd0, imem_addr}, 32'h00);
      tick();
      rst_n      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 16'h0920;
      #1;
      check("async_req_drop", {31'd0, imem_req}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("late_ack_req", {31'd0, imem_req}, 32'd1);
         check("late_ack_addr", {24'd0, imem_addr}, 32'h00);
         check("late_ack_no_strobes", {30'd0, rf_we, flags_we}, 32'd0);
         tick();
      end
      run_instr(16'h0920);
      check("post_rst_add_we", {30'd0, rf_we, flags_we}, 32'd3);
      tick();
      check("post_rst_addr", {24'd0, imem_addr}, 32'h02);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
